multiplier_unit: RTL and testbench

Sequential 32x32 integer multiplier with architectural HI/LO result registers for the single-cycle MIPS datapath. It sits downstream of the operand-select stage (register file / extended-immediate mux) and beside the ALU. It executes MULT and MULTU by shift-and-add over 32 cycles and holds the 64-bit product in HI/LO for MFHI/MFLO. The control unit stalls the PC while `busy` is high.

---
 rtl/multiplier_unit.sv | 85 ++++++++
 tb/tb_multiplier_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_unit.sv
// Shift-and-add 32x32 MULT/MULTU with HI/LO registers; product lands 32 cycles after start is accepted.
// No queueing: start is ignored while busy, and the control unit must stall the PC while busy is high.
module multiplier_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      count;
   logic               neg;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] prod;

   // The most negative operand keeps its magnitude as an unsigned value, so no overflow.
   assign mag_a    = (signed_op && dataA[WIDTH-1]) ? -dataA : dataA;
   assign mag_b    = (signed_op && dataB[WIDTH-1]) ? -dataB : dataB;
   assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
   assign acc_next = {sum, acc[WIDTH-1:1]};
   assign prod     = neg ? -acc_next : acc_next;

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         neg    <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else if (state == RUN) begin
         acc    <= acc_next;
         mplier <= mplier >> 1;
         count  <= count + CW'(1);
         if (count == LAST) begin
            hi    <= prod[2*WIDTH-1:WIDTH];
            lo    <= prod[WIDTH-1:0];
            state <= DONE;
         end
      end else begin
         // IDLE and DONE behave alike: MTHI/MTLO allowed, start accepted back-to-back.
         if (hi_we) hi <= wdata;
         if (lo_we) lo <= wdata;
         if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= signed_op & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
         end else begin
            state  <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_multiplier_unit.sv
// Self-checking bench for multiplier_unit: directed corners plus randomized operands
// checked against a plain 64-bit multiply reference.
module tb_multiplier_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        signed_op;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   multiplier_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
      .dataA(dataA), .dataB(dataB), .hi_we(hi_we), .lo_we(lo_we),
      .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [63:0] ea, eb;
      ea = s ? {{32{a[31]}}, a} : {32'h0, a};
      eb = s ? {{32{b[31]}}, b} : {32'h0, b};
      return ea * eb;
   endfunction

   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
      dataA = a; dataB = b; signed_op = s; start = 1'b1;
   endtask

   // Call at a negedge right after launch(); returns at the negedge where busy first drops.
   task automatic wait_done(output int cyc, output logic dn);
      cyc = 0; dn = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
         if (busy) cyc++;
         else begin dn = done; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 0; signed_op = 0; dataA = 0; dataB = 0;
      hi_we = 0; lo_we = 0; wdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
      end
      rst = 1'b0;
   endtask

   task automatic test_multu_basic;
      int cyc; logic dn;
      @(negedge clk);
      launch(32'd3, 32'd5, 1'b0);
      wait_done(cyc, dn);
      checks++;
      if (cyc !== 32) begin errors++; $display("FAIL basic_busy_len: got %0d want 32", cyc); end
      checks++;
      if (dn !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", dn); end
      checks++;
      if ({hi, lo} !== 64'h0000_0000_0000_000F) begin
         errors++; $display("FAIL basic_product: got %h_%h want 00000000_0000000f", hi, lo);
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++; $display("FAIL done_one_cycle: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_corners;
      logic [31:0] ta [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000,
                              32'h80000000, 32'h80000000, 32'h00000000};
      logic [31:0] tb [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000005, 32'h80000000,
                              32'h00000001, 32'hFFFFFFFF, 32'hDEADBEEF};
      logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [63:0] te [7] = '{64'hFFFFFFFE_00000001, 64'h00000000_00000001,
                              64'hFFFFFFFF_FFFFFFF1, 64'h40000000_00000000,
                              64'hFFFFFFFF_80000000, 64'h00000000_80000000,
                              64'h00000000_00000000};
      int cyc; logic dn;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         launch(ta[k], tb[k], ts[k]);
         wait_done(cyc, dn);
         checks++;
         if ({hi, lo} !== te[k] || dn !== 1'b1) begin
            errors++;
            $display("FAIL corner%0d: got %h_%h done=%b want %h done=1", k, hi, lo, dn, te[k]);
         end
      end
   endtask

   task automatic test_random;
      logic [31:0] a, b; logic s; logic [63:0] exp;
      int cyc; logic dn;
      for (int k = 0; k < 20; k++) begin
         a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
         exp = ref_mul(a, b, s);
         @(negedge clk);
         launch(a, b, s);
         wait_done(cyc, dn);
         checks++;
         if ({hi, lo} !== exp || cyc !== 32) begin
            errors++;
            $display("FAIL random%0d: %h*%h s=%b got %h_%h cyc=%0d want %h cyc=32",
                     k, a, b, s, hi, lo, cyc, exp);
         end
      end
   endtask

   task automatic test_ignore_start;
      int cyc = 0;
      @(negedge clk);
      launch(32'd7, 32'd6, 1'b0);
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) start = 1'b0;
         if (i == 10) begin start = 1'b1; dataA = 32'd2; dataB = 32'd2; end
         if (i == 11) start = 1'b0;
         if (busy) cyc++;
         else break;
      end
      checks++;
      if ({hi, lo} !== 64'd42 || cyc !== 32 || done !== 1'b1) begin
         errors++;
         $display("FAIL ignore_start: got %h_%h cyc=%0d done=%b want 42 cyc=32 done=1", hi, lo, cyc, done);
      end
   endtask

   task automatic test_back_to_back;
      int cyc; logic dn;
      @(negedge clk);
      launch(32'd11, 32'd13, 1'b0);
      wait_done(cyc, dn);
      checks++;
      if (lo !== 32'd143 || dn !== 1'b1) begin
         errors++; $display("FAIL b2b_first: lo=%0d done=%b want 143 1", lo, dn);
      end
      launch(32'hFFFFFFFC, 32'd25, 1'b1);
      wait_done(cyc, dn);
      checks++;
      if ({hi, lo} !== 64'hFFFFFFFF_FFFFFF9C || cyc !== 32 || dn !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: got %h_%h cyc=%0d done=%b want ffffffff_ffffff9c cyc=32", hi, lo, cyc, dn);
      end
   endtask

   task automatic test_mtlo_mthi;
      @(negedge clk);
      lo_we = 1'b1; wdata = 32'h12345678;
      @(negedge clk);
      lo_we = 1'b0;
      checks++;
      if (lo !== 32'h12345678) begin errors++; $display("FAIL mtlo: got %h want 12345678", lo); end
      hi_we = 1'b1; wdata = 32'hCAFEF00D;
      @(negedge clk);
      hi_we = 1'b0;
      checks++;
      if (hi !== 32'hCAFEF00D) begin errors++; $display("FAIL mthi: got %h want cafef00d", hi); end
   endtask

   task automatic test_mthi_during_run;
      int n = 0;
      @(negedge clk);
      launch(32'd2, 32'd3, 1'b0);
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) start = 1'b0;
         if (i == 3) begin hi_we = 1'b1; wdata = 32'hDEADBEEF; end
         if (i == 4) hi_we = 1'b0;
      end
      checks++;
      if (hi !== 32'hCAFEF00D) begin errors++; $display("FAIL mthi_run: got %h want cafef00d", hi); end
      while (busy && n < 40) begin @(negedge clk); n++; end
      checks++;
      if ({hi, lo} !== 64'd6 || done !== 1'b1) begin
         errors++; $display("FAIL mthi_run_product: got %h_%h done=%b want 6", hi, lo, done);
      end
   endtask

   task automatic test_lo_we_product_edge;
      int cyc = 0;
      @(negedge clk);
      launch(32'd1000, 32'd1000, 1'b0);
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) start = 1'b0;
         if (!busy) break;
         cyc++;
         if (cyc == 32) begin lo_we = 1'b1; wdata = 32'h5A5A5A5A; end
      end
      lo_we = 1'b0;
      checks++;
      if ({hi, lo} !== 64'd1000000) begin
         errors++; $display("FAIL lo_we_product_edge: got %h_%h want 000f4240", hi, lo);
      end
   endtask

   task automatic test_mtlo_with_start;
      int n = 0;
      @(negedge clk);
      launch(32'd5, 32'd5, 1'b0);
      lo_we = 1'b1; wdata = 32'h0BADCAFE;
      @(negedge clk);
      lo_we = 1'b0; start = 1'b0;
      checks++;
      if (lo !== 32'h0BADCAFE || busy !== 1'b1) begin
         errors++; $display("FAIL mtlo_with_start: lo=%h busy=%b want 0badcafe 1", lo, busy);
      end
      while (busy && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (lo !== 32'd25) begin errors++; $display("FAIL mtlo_then_product: lo=%0d want 25", lo); end
   endtask

   task automatic test_reset_abort;
      int cyc = 0; int done_seen = 0; logic dn;
      @(negedge clk);
      launch(32'd9, 32'd9, 1'b0);
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) start = 1'b0;
         if (busy) cyc++;
         if (cyc == 20) begin rst = 1'b1; break; end
      end
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         errors++;
         $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      checks++;
      if (done_seen !== 0) begin
         errors++; $display("FAIL reset_no_done: saw %0d busy/done cycles want 0", done_seen);
      end
      @(negedge clk);
      launch(32'd9, 32'd9, 1'b0);
      wait_done(cyc, dn);
      checks++;
      if ({hi, lo} !== 64'd81 || dn !== 1'b1) begin
         errors++; $display("FAIL after_abort: got %h_%h done=%b want 81", hi, lo, dn);
      end
   endtask

   initial begin
      test_reset;
      test_multu_basic;
      test_corners;
      test_random;
      test_ignore_start;
      test_back_to_back;
      test_mtlo_mthi;
      test_mthi_during_run;
      test_lo_we_product_edge;
      test_mtlo_with_start;
      test_reset_abort;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
